f1_random_delay: RTL and testbench

// - Random-delay responder for the start-light controller: owns the start_delay -> time_out handshake.
// - A start_delay pulse loads a pseudo-random hold time in milliseconds; the block counts it down on the
//   1 ms tick and then pulses time_out. The lights FSM turns all LEDs off on that pulse.
// - Contains the LFSR that the controller's en_lfsr output advances.
//   The lights FSM drives start_delay/en_lfsr; this block feeds time_out back to it.

---
 rtl/f1_random_delay.sv | 66 ++++++
 tb/tb_f1_random_delay.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/f1_random_delay.sv
// f1_random_delay: LFSR-seeded random hold timer that answers start_delay with a time_out pulse
module f1_random_delay #(
  parameter int          MIN_MS    = 200,
  parameter int          MAX_MS    = 3000,
  parameter int          RAND_BITS = 12,
  parameter int          CNT_W     = 12,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en_lfsr,
  input  logic             start_delay,
  output logic             time_out,
  output logic             busy,
  output logic [CNT_W-1:0] delay_ms
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, delay_q, delay_d, load;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [CNT_W:0]   sum;
  assign sum  = (CNT_W+1)'(MIN_MS) + (CNT_W+1)'(lfsr_q[RAND_BITS-1:0]);
  assign load = (sum > (CNT_W+1)'(MAX_MS)) ? CNT_W'(MAX_MS) : sum[CNT_W-1:0];
  // a zero LFSR would lock up, so it is forced back to SEED even when not enabled
  assign lfsr_d = (lfsr_q == '0) ? SEED :
                  en_lfsr ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  // hold-time FSM: a restart in COUNT wins over a tick; DONE lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    case (state_q)
      IDLE, COUNT: begin
        if (start_delay) begin
          state_d = COUNT;
          cnt_d   = load;
          delay_d = load;
        end else if (state_q == COUNT && tick) begin
          cnt_d   = (cnt_q > CNT_W'(1)) ? cnt_q - CNT_W'(1) : '0;
          state_d = (cnt_q > CNT_W'(1)) ? COUNT : DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset mid-count simply drops the count
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      delay_q <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      lfsr_q  <= lfsr_d;
    end
  end
  assign time_out = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign delay_ms = delay_q;
endmodule

// File: tb/tb_f1_random_delay.sv
// tb_f1_random_delay: scoreboard bench for default and small-parameter random delay instances
module tb_f1_random_delay;
  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;
  logic tick_a = 0, en_a = 0, st_a = 0, to_a, busy_a;
  logic tick_b = 0, en_b = 0, st_b = 0, to_b, busy_b;
  logic [11:0] dly_a, dly_b;
  f1_random_delay dut_a (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick_a), .en_lfsr(en_a), .start_delay(st_a),
    .time_out(to_a), .busy(busy_a), .delay_ms(dly_a)
  );
  f1_random_delay #(.MIN_MS(2), .MAX_MS(20), .RAND_BITS(4), .CNT_W(12), .SEED(16'h0001)) dut_b (
    .sysclk(sysclk), .rst_n(rst_n), .tick(tick_b), .en_lfsr(en_b), .start_delay(st_b),
    .time_out(to_b), .busy(busy_b), .delay_ms(dly_b)
  );
  int tests = 0, fails = 0;
  int q_a[$], q_b[$];
  int nt_a = 0, nt_b = 0, pulses_a = 0, pulses_b = 0, e_a, e_b;
  logic [15:0] m_a = 16'hACE1, m_b = 16'h0001;
  function automatic logic [15:0] nxt(input logic [15:0] l, input logic [15:0] s);
    return (l == 16'h0) ? s : {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction
  function automatic int load_a(input logic [15:0] l);
    int s = 200 + int'(l[11:0]);
    return (s > 3000) ? 3000 : s;
  endfunction
  function automatic int load_b(input logic [15:0] l);
    int s = 2 + int'(l[3:0]);
    return (s > 20) ? 20 : s;
  endfunction
  // reference LFSRs
  always @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= 16'hACE1;
      m_b <= 16'h0001;
    end else begin
      if (en_a || m_a == 16'h0) m_a <= nxt(m_a, 16'hACE1);
      if (en_b || m_b == 16'h0) m_b <= nxt(m_b, 16'h0001);
    end
  end
  // scoreboard: each time_out must match the pending load and the ticks counted since it
  always @(negedge sysclk) begin
    if (rst_n && to_a) begin
      pulses_a++;
      tests++;
      if (q_a.size() == 0) begin
        fails++;
        $display("FAIL sb_a: unexpected time_out, delay_ms=%0d", dly_a);
      end else begin
        e_a = q_a.pop_front();
        if (dly_a !== 12'(e_a) || nt_a != e_a) begin
          fails++;
          $display("FAIL sb_a: delay_ms=%0d ticks=%0d, expected %0d", dly_a, nt_a, e_a);
        end
      end
    end
    if (rst_n && to_b) begin
      pulses_b++;
      tests++;
      if (q_b.size() == 0) begin
        fails++;
        $display("FAIL sb_b: unexpected time_out, delay_ms=%0d", dly_b);
      end else begin
        e_b = q_b.pop_front();
        if (dly_b !== 12'(e_b) || nt_b != e_b) begin
          fails++;
          $display("FAIL sb_b: delay_ms=%0d ticks=%0d, expected %0d", dly_b, nt_b, e_b);
        end
      end
    end
  end
  task automatic step;
    @(posedge sysclk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic start_a;
    st_a = 1;
    q_a.delete();
    q_a.push_back(load_a(m_a));
    nt_a = 0;
    step;
    st_a = 0;
  endtask
  task automatic start_b(input logic with_tick);
    st_b = 1;
    tick_b = with_tick;
    q_b.delete();
    q_b.push_back(load_b(m_b));
    nt_b = 0;
    step;
    st_b = 0;
    tick_b = 0;
  endtask
  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) step;
      tick_a = 1;
      nt_a++;
      step;
      tick_a = 0;
    end
  endtask
  task automatic ticks_b(input int n);
    for (int i = 0; i < n; i++) begin
      if (i != 0) step;
      tick_b = 1;
      nt_b++;
      step;
      tick_b = 0;
    end
  endtask
  task automatic test_reset;
    repeat (2) step;
    chk("rst_time_out", int'(to_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_delay_ms", int'(dly_a), 0);
    chk("rst_lfsr", int'(dut_a.lfsr_q), 16'hACE1);
    chk("rst_lfsr_b", int'(dut_b.lfsr_q), 1);
    @(negedge sysclk);
    rst_n = 1;
    step;
  endtask
  task automatic test_clamp;
    start_a;
    chk("clamp_delay_ms", int'(dly_a), 3000);
    chk("clamp_busy", int'(busy_a), 1);
    ticks_a(2999);
    chk("clamp_early", int'(to_a), 0);
    ticks_a(1);
    chk("clamp_time_out", int'(to_a), 1);
    step;
    chk("clamp_width", int'(to_a), 0);
    chk("clamp_busy_end", int'(busy_a), 0);
    chk("clamp_pulses", pulses_a, 1);
  endtask
  task automatic test_small;
    start_b(1'b0);
    chk("small_delay_ms", int'(dly_b), 3);
    ticks_b(2);
    chk("small_early", int'(to_b), 0);
    ticks_b(1);
    chk("small_time_out", int'(to_b), 1);
    chk("small_busy_done", int'(busy_b), 1);
    st_b = 1;
    step;
    st_b = 0;
    chk("small_width", int'(to_b), 0);
    chk("small_done_ignores_start", int'(busy_b), 0);
    chk("small_delay_hold", int'(dly_b), 3);
    chk("small_pulses", pulses_b, 1);
  endtask
  task automatic test_coincident;
    start_b(1'b1);
    chk("coin_delay_ms", int'(dly_b), 3);
    ticks_b(2);
    chk("coin_early", int'(to_b), 0);
    ticks_b(1);
    chk("coin_time_out", int'(to_b), 1);
    step;
    chk("coin_pulses", pulses_b, 2);
  endtask
  task automatic test_restart;
    start_b(1'b0);
    ticks_b(1);
    en_b = 1;
    repeat (2) step;
    en_b = 0;
    start_b(1'b0);
    chk("restart_delay_ms", int'(dly_b), 6);
    ticks_b(5);
    chk("restart_early", int'(to_b), 0);
    ticks_b(1);
    chk("restart_time_out", int'(to_b), 1);
    step;
    chk("restart_pulses", pulses_b, 3);
  endtask
  task automatic test_reset_mid;
    start_a;
    ticks_a(5);
    #3;
    rst_n = 0;
    #1;
    chk("mid_time_out", int'(to_a), 0);
    chk("mid_busy", int'(busy_a), 0);
    chk("mid_delay_ms", int'(dly_a), 0);
    chk("mid_lfsr", int'(dut_a.lfsr_q), 16'hACE1);
    q_a.delete();
    @(negedge sysclk);
    rst_n = 1;
    step;
    ticks_a(3000);
    step;
    chk("mid_no_time_out", pulses_a, 1);
    chk("mid_idle", int'(busy_a), 0);
  endtask
  task automatic test_lfsr;
    int first_bad = -1;
    int zeros = 0;
    en_a = 1;
    for (int i = 0; i < 65535; i++) begin
      step;
      if (dut_a.lfsr_q == 16'h0) zeros++;
      if (first_bad < 0 && dut_a.lfsr_q !== m_a) begin
        first_bad = i;
        $display("FAIL lfsr_seq: cycle %0d got %h, expected %h", i, dut_a.lfsr_q, m_a);
      end
    end
    en_a = 0;
    tests++;
    if (first_bad >= 0) fails++;
    chk("lfsr_zero", zeros, 0);
    chk("lfsr_period", int'(dut_a.lfsr_q), 16'hACE1);
  endtask
  initial begin
    test_reset;
    test_clamp;
    test_small;
    test_coincident;
    test_restart;
    test_reset_mid;
    test_lfsr;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
